// File: rtl/ex_alu_muldiv.sv
// MIPS execute stage: registered single-cycle ALU plus an iterative shift-add multiplier /
// restoring divider that owns the architectural HI/LO pair.
module ex_alu_muldiv #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             In_valid,
   output logic             In_ready,
   input  logic [31:0]      Ins,
   input  logic [WIDTH-1:0] Rdata1,
   input  logic [WIDTH-1:0] Rdata2,
   input  logic [WIDTH-1:0] Ed,
   output logic [WIDTH-1:0] Result,
   output logic             Out_valid,
   output logic             Ovf,
   output logic             Illegal,
   output logic             Md_busy,
   output logic             Md_done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int IMW = (WIDTH < 16) ? WIDTH : 16;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t state, state_nxt;

   logic [5:0]       op, funct;
   logic [SHW-1:0]   sh_imm, sh_var;
   logic [WIDTH-1:0] zext_imm, opb, sum, diff;
   logic             add_ovf, sub_ovf, slt, sltu;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf, alu_ill, wr_hi, wr_lo;
   logic             is_md, is_div, md_signed;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             accept;
   logic             unused_ins;

   logic [WIDTH:0]     acc;
   logic [WIDTH-1:0]   qr, md_b, md_a;
   logic               neg_q, neg_r, div_zero;
   logic [SHW:0]       cnt;
   logic               iter_done;
   logic [WIDTH:0]     mul_sum, div_rsh, div_diff;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   q_fix, r_fix;

   assign accept     = In_valid && In_ready;
   assign In_ready   = (state == IDLE);
   assign Md_busy    = (state != IDLE);
   assign unused_ins = ^Ins[25:11];

   // Decode and single-cycle ALU; everything here is registered on the accepting edge.
   always_comb begin
      op       = Ins[31:26];
      funct    = Ins[5:0];
      sh_imm   = SHW'(Ins[10:6]);
      sh_var   = Rdata1[SHW-1:0];
      zext_imm = '0;
      zext_imm[IMW-1:0] = Ed[IMW-1:0];
      opb      = (op == 6'h00) ? Rdata2 : Ed;
      sum      = Rdata1 + opb;
      diff     = Rdata1 - opb;
      add_ovf  = (Rdata1[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != Rdata1[WIDTH-1]);
      sub_ovf  = (Rdata1[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != Rdata1[WIDTH-1]);
      slt      = $signed(Rdata1) < $signed(opb);
      sltu     = Rdata1 < opb;
      alu_res   = '0;
      alu_ovf   = 1'b0;
      alu_ill   = 1'b0;
      wr_hi     = 1'b0;
      wr_lo     = 1'b0;
      is_md     = 1'b0;
      is_div    = 1'b0;
      md_signed = 1'b0;
      if (op == 6'h00) begin
         case (funct)
            6'h00: alu_res = Rdata2 << sh_imm;
            6'h02: alu_res = Rdata2 >> sh_imm;
            6'h03: alu_res = $signed(Rdata2) >>> sh_imm;
            6'h04: alu_res = Rdata2 << sh_var;
            6'h06: alu_res = Rdata2 >> sh_var;
            6'h07: alu_res = $signed(Rdata2) >>> sh_var;
            6'h10: alu_res = Hi;
            6'h11: wr_hi = 1'b1;
            6'h12: alu_res = Lo;
            6'h13: wr_lo = 1'b1;
            6'h18, 6'h19, 6'h1A, 6'h1B: begin
               is_md     = 1'b1;
               is_div    = funct[1];
               md_signed = ~funct[0];
            end
            6'h20: begin alu_res = sum;  alu_ovf = add_ovf; end
            6'h21: alu_res = sum;
            6'h22: begin alu_res = diff; alu_ovf = sub_ovf; end
            6'h23: alu_res = diff;
            6'h24: alu_res = Rdata1 & Rdata2;
            6'h25: alu_res = Rdata1 | Rdata2;
            6'h26: alu_res = Rdata1 ^ Rdata2;
            6'h27: alu_res = ~(Rdata1 | Rdata2);
            6'h2A: alu_res = {{(WIDTH-1){1'b0}}, slt};
            6'h2B: alu_res = {{(WIDTH-1){1'b0}}, sltu};
            default: alu_ill = 1'b1;
         endcase
      end else begin
         case (op)
            6'h08: begin alu_res = sum; alu_ovf = add_ovf; end
            6'h09: alu_res = sum;
            6'h0A: alu_res = {{(WIDTH-1){1'b0}}, slt};
            6'h0B: alu_res = {{(WIDTH-1){1'b0}}, sltu};
            6'h0C: alu_res = Rdata1 & zext_imm;
            6'h0D: alu_res = Rdata1 | zext_imm;
            6'h0E: alu_res = Rdata1 ^ zext_imm;
            6'h0F: begin
               if (WIDTH >= 32) alu_res = zext_imm << 16;
               else             alu_ill = 1'b1;
            end
            default: alu_ill = 1'b1;
         endcase
      end
      a_neg = md_signed & Rdata1[WIDTH-1];
      b_neg = md_signed & Rdata2[WIDTH-1];
      a_mag = a_neg ? -Rdata1 : Rdata1;
      b_mag = b_neg ? -Rdata2 : Rdata2;
   end

   // One iteration step of the shared accumulator, plus the sign fix-up applied on the last cycle.
   always_comb begin
      iter_done = (cnt == (SHW+1)'(WIDTH));
      mul_sum   = acc + (qr[0] ? {1'b0, md_b} : {(WIDTH+1){1'b0}});
      div_rsh   = {acc[WIDTH-1:0], qr[WIDTH-1]};
      div_diff  = div_rsh - {1'b0, md_b};
      prod      = {acc[WIDTH-1:0], qr};
      prod_fix  = neg_q ? -prod : prod;
      q_fix     = neg_q ? -qr : qr;
      r_fix     = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept && is_md) state_nxt = is_div ? DIV : MUL;
         MUL:  if (iter_done) state_nxt = IDLE;
         DIV:  if (div_zero || iter_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Result/flag registers, HI/LO and the iterative mul/div datapath.
   always_ff @(posedge CLK) begin
      if (RST) begin
         Result    <= '0;
         Out_valid <= 1'b0;
         Ovf       <= 1'b0;
         Illegal   <= 1'b0;
         Md_done   <= 1'b0;
         Hi        <= '0;
         Lo        <= '0;
         acc       <= '0;
         qr        <= '0;
         md_b      <= '0;
         md_a      <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         div_zero  <= 1'b0;
         cnt       <= '0;
      end else begin
         Out_valid <= 1'b0;
         Md_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_md) begin
                     acc      <= '0;
                     qr       <= a_mag;
                     md_b     <= b_mag;
                     md_a     <= Rdata1;
                     neg_q    <= a_neg ^ b_neg;
                     neg_r    <= a_neg;
                     div_zero <= (Rdata2 == '0);
                     cnt      <= '0;
                  end else begin
                     Result    <= alu_res;
                     Ovf       <= alu_ovf;
                     Illegal   <= alu_ill;
                     Out_valid <= 1'b1;
                     if (wr_hi) Hi <= Rdata1;
                     if (wr_lo) Lo <= Rdata1;
                  end
               end
            end
            MUL: begin
               if (iter_done) begin
                  Hi      <= prod_fix[2*WIDTH-1:WIDTH];
                  Lo      <= prod_fix[WIDTH-1:0];
                  Md_done <= 1'b1;
               end else begin
                  acc <= {1'b0, mul_sum[WIDTH:1]};
                  qr  <= {mul_sum[0], qr[WIDTH-1:1]};
                  cnt <= cnt + 1'b1;
               end
            end
            DIV: begin
               if (div_zero) begin
                  Hi      <= md_a;
                  Lo      <= '1;
                  Md_done <= 1'b1;
               end else if (iter_done) begin
                  Hi      <= r_fix;
                  Lo      <= q_fix;
                  Md_done <= 1'b1;
               end else begin
                  if (!div_diff[WIDTH]) begin
                     acc <= div_diff;
                     qr  <= {qr[WIDTH-2:0], 1'b1};
                  end else begin
                     acc <= div_rsh;
                     qr  <= {qr[WIDTH-2:0], 1'b0};
                  end
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_alu_muldiv.sv
// Directed bench for ex_alu_muldiv: a 32-bit and a 16-bit instance share one stimulus port,
// with sel choosing which instance is driven and observed.
module tb_ex_alu_muldiv;

   logic        CLK = 1'b0;
   logic        RST;
   logic        In_valid;
   logic [31:0] Ins, Rdata1, Rdata2, Ed;
   logic        sel;

   logic        in_ready32, out_valid32, ovf32, illegal32, md_busy32, md_done32;
   logic [31:0] result32, hi32, lo32;
   logic        in_ready16, out_valid16, ovf16, illegal16, md_busy16, md_done16;
   logic [15:0] result16, hi16, lo16;

   logic        v_ready, v_valid, v_ovf, v_ill, v_busy, v_done;
   logic [31:0] v_result, v_hi, v_lo;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   ex_alu_muldiv #(.WIDTH(32), .SHW(5)) u_dut32 (
      .CLK(CLK), .RST(RST), .In_valid(In_valid & ~sel), .In_ready(in_ready32),
      .Ins(Ins), .Rdata1(Rdata1), .Rdata2(Rdata2), .Ed(Ed),
      .Result(result32), .Out_valid(out_valid32), .Ovf(ovf32), .Illegal(illegal32),
      .Md_busy(md_busy32), .Md_done(md_done32), .Hi(hi32), .Lo(lo32));

   ex_alu_muldiv #(.WIDTH(16), .SHW(4)) u_dut16 (
      .CLK(CLK), .RST(RST), .In_valid(In_valid & sel), .In_ready(in_ready16),
      .Ins(Ins), .Rdata1(Rdata1[15:0]), .Rdata2(Rdata2[15:0]), .Ed(Ed[15:0]),
      .Result(result16), .Out_valid(out_valid16), .Ovf(ovf16), .Illegal(illegal16),
      .Md_busy(md_busy16), .Md_done(md_done16), .Hi(hi16), .Lo(lo16));

   assign v_ready  = sel ? in_ready16  : in_ready32;
   assign v_valid  = sel ? out_valid16 : out_valid32;
   assign v_ovf    = sel ? ovf16       : ovf32;
   assign v_ill    = sel ? illegal16   : illegal32;
   assign v_busy   = sel ? md_busy16   : md_busy32;
   assign v_done   = sel ? md_done16   : md_done32;
   assign v_result = sel ? {16'h0, result16} : result32;
   assign v_hi     = sel ? {16'h0, hi16}     : hi32;
   assign v_lo     = sel ? {16'h0, lo16}     : lo32;

   function automatic logic [31:0] rt(input logic [5:0] f, input logic [4:0] sa);
      return {6'd0, 15'd0, sa, f};
   endfunction

   function automatic logic [31:0] it(input logic [5:0] op);
      return {op, 26'd0};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one instruction for exactly one accepting edge; returns 1 time unit after that edge.
   task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] ed);
      @(negedge CLK);
      Ins = ins; Rdata1 = r1; Rdata2 = r2; Ed = ed; In_valid = 1'b1;
      @(posedge CLK);
      #1;
      In_valid = 1'b0;
   endtask

   task automatic aluCheck(input string tag, input logic [31:0] ins, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] ed,
                           input logic [31:0] exp_res, input logic exp_ovf, input logic exp_ill);
      applyStimulus(ins, r1, r2, ed);
      checkOutput({tag, ".valid"}, v_valid, 1);
      checkOutput({tag, ".res"}, v_result, exp_res);
      checkOutput({tag, ".ovf"}, v_ovf, exp_ovf);
      checkOutput({tag, ".ill"}, v_ill, exp_ill);
      @(posedge CLK);
      #1;
      checkOutput({tag, ".pulse"}, v_valid, 0);
   endtask

   task automatic mdCheck(input string tag, input logic [31:0] ins, input logic [31:0] r1,
                          input logic [31:0] r2, input int exp_edges,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int  edges;
      logic ready_seen, valid_seen, busy_ok;
      applyStimulus(ins, r1, r2, 32'h0);
      Rdata1 = 32'h5A5A5A5A;
      Rdata2 = 32'hA5A5A5A5;
      edges = 0; ready_seen = 0; valid_seen = 0; busy_ok = 1;
      while (v_done !== 1'b1 && edges < 200) begin
         if (v_ready)  ready_seen = 1;
         if (v_valid)  valid_seen = 1;
         if (!v_busy)  busy_ok = 0;
         @(posedge CLK);
         #1;
         edges++;
      end
      checkOutput({tag, ".done"}, v_done, 1);
      checkOutput({tag, ".lat"}, edges, exp_edges);
      checkOutput({tag, ".ready_low"}, ready_seen, 0);
      checkOutput({tag, ".no_valid"}, valid_seen, 0);
      checkOutput({tag, ".busy"}, busy_ok, 1);
      checkOutput({tag, ".hi"}, v_hi, exp_hi);
      checkOutput({tag, ".lo"}, v_lo, exp_lo);
      checkOutput({tag, ".idle"}, v_ready, 1);
      @(posedge CLK);
      #1;
      checkOutput({tag, ".done_pulse"}, v_done, 0);
   endtask

   initial begin
      logic done_seen;
      sel = 1'b0; RST = 1'b1; In_valid = 1'b0;
      Ins = '0; Rdata1 = '0; Rdata2 = '0; Ed = '0;
      repeat (2) @(posedge CLK);
      #1;
      checkOutput("rst.ready", v_ready, 1);
      checkOutput("rst.busy", v_busy, 0);
      checkOutput("rst.valid", v_valid, 0);
      checkOutput("rst.done", v_done, 0);
      checkOutput("rst.res", v_result, 0);
      checkOutput("rst.hi", v_hi, 0);
      checkOutput("rst.lo", v_lo, 0);
      RST = 1'b0;

      aluCheck("add_ovf",  rt(6'h20, 0), 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 1, 0);
      aluCheck("addu",     rt(6'h21, 0), 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 0);
      aluCheck("sub_ovf",  rt(6'h22, 0), 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 1, 0);
      aluCheck("subu",     rt(6'h23, 0), 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 0, 0);
      aluCheck("sra",      rt(6'h03, 4), 0, 32'h80000000, 0, 32'hF8000000, 0, 0);
      aluCheck("sll31",    rt(6'h00, 31), 0, 32'h1, 0, 32'h80000000, 0, 0);
      aluCheck("srlv",     rt(6'h06, 0), 32'd36, 32'hF0, 0, 32'h0000000F, 0, 0);
      aluCheck("sltu",     rt(6'h2B, 0), 32'h1, 32'hFFFFFFFF, 0, 32'h1, 0, 0);
      aluCheck("slt",      rt(6'h2A, 0), 32'h1, 32'hFFFFFFFF, 0, 32'h0, 0, 0);
      aluCheck("nor",      rt(6'h27, 0), 0, 0, 0, 32'hFFFFFFFF, 0, 0);
      aluCheck("addi_ovf", it(6'h08), 32'h7FFFFFFF, 0, 32'h1, 32'h80000000, 1, 0);
      aluCheck("addiu",    it(6'h09), 32'h7FFFFFFF, 0, 32'h1, 32'h80000000, 0, 0);
      aluCheck("slti",     it(6'h0A), 32'h5, 0, 32'hFFFFFFFF, 32'h0, 0, 0);
      aluCheck("sltiu",    it(6'h0B), 32'h5, 0, 32'hFFFFFFFF, 32'h1, 0, 0);
      aluCheck("andi",     it(6'h0C), 32'hFFFFFFFF, 0, 32'hFFFF8001, 32'h00008001, 0, 0);
      aluCheck("xori",     it(6'h0E), 32'h0000FFFF, 0, 32'hFFFF00FF, 32'h0000FF00, 0, 0);
      aluCheck("lui",      it(6'h0F), 0, 0, 32'h00001234, 32'h12340000, 0, 0);
      aluCheck("ill_fn",   rt(6'h01, 0), 32'h3, 32'h4, 0, 32'h0, 0, 1);
      aluCheck("ill_op",   it(6'h3F), 32'h3, 32'h4, 32'h5, 32'h0, 0, 1);

      // Two ALU ops accepted on consecutive edges with In_valid held high.
      @(negedge CLK);
      Ins = rt(6'h21, 0); Rdata1 = 32'h1; Rdata2 = 32'h2; In_valid = 1'b1;
      @(posedge CLK);
      #1;
      checkOutput("b2b0.valid", v_valid, 1);
      checkOutput("b2b0.res", v_result, 32'h3);
      Ins = rt(6'h26, 0); Rdata1 = 32'hF0; Rdata2 = 32'hFF;
      @(posedge CLK);
      #1;
      In_valid = 1'b0;
      checkOutput("b2b1.valid", v_valid, 1);
      checkOutput("b2b1.res", v_result, 32'h0F);

      mdCheck("mult", rt(6'h18, 0), 32'hFFFFFFFD, 32'h7, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
      aluCheck("mflo", rt(6'h12, 0), 0, 0, 0, 32'hFFFFFFEB, 0, 0);
      aluCheck("mfhi", rt(6'h10, 0), 0, 0, 0, 32'hFFFFFFFF, 0, 0);
      aluCheck("mthi", rt(6'h11, 0), 32'h0000DEAD, 0, 0, 32'h0, 0, 0);
      aluCheck("mfhi2", rt(6'h10, 0), 0, 0, 0, 32'h0000DEAD, 0, 0);
      mdCheck("multu", rt(6'h19, 0), 32'hFFFFFFFF, 32'h2, 33, 32'h1, 32'hFFFFFFFE);
      mdCheck("div",   rt(6'h1A, 0), 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
      mdCheck("divu0", rt(6'h1B, 0), 32'h7, 32'h0, 1, 32'h7, 32'hFFFFFFFF);
      mdCheck("divmin", rt(6'h1A, 0), 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);
      mdCheck("divu",  rt(6'h1B, 0), 32'd100, 32'd7, 33, 32'd2, 32'd14);

      // Synchronous reset landing on the tenth edge of a divide.
      applyStimulus(rt(6'h1A, 0), 32'd1000, 32'd3, 0);
      repeat (9) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      checkOutput("rstdiv.ready", v_ready, 1);
      checkOutput("rstdiv.busy", v_busy, 0);
      checkOutput("rstdiv.hi", v_hi, 0);
      checkOutput("rstdiv.lo", v_lo, 0);
      checkOutput("rstdiv.done", v_done, 0);
      RST = 1'b0;
      done_seen = 0;
      repeat (40) begin
         @(posedge CLK);
         #1;
         if (v_done) done_seen = 1;
      end
      checkOutput("rstdiv.no_done", done_seen, 0);

      sel = 1'b1;
      aluCheck("w16.add_ovf", rt(6'h20, 0), 32'h7FFF, 32'h1, 0, 32'h8000, 1, 0);
      aluCheck("w16.lui",     it(6'h0F), 0, 0, 32'h1234, 32'h0, 0, 1);
      aluCheck("w16.sra",     rt(6'h03, 4), 0, 32'h8000, 0, 32'hF800, 0, 0);
      aluCheck("w16.srlv",    rt(6'h06, 0), 32'd20, 32'hF0, 0, 32'h000F, 0, 0);
      aluCheck("w16.slt",     rt(6'h2A, 0), 32'h1, 32'hFFFF, 0, 32'h0, 0, 0);
      aluCheck("w16.sltu",    rt(6'h2B, 0), 32'h1, 32'hFFFF, 0, 32'h1, 0, 0);
      mdCheck("w16.mult", rt(6'h18, 0), 32'hFFFD, 32'h7, 17, 32'hFFFF, 32'hFFEB);
      mdCheck("w16.div",  rt(6'h1A, 0), 32'hFFF9, 32'h2, 17, 32'hFFFF, 32'hFFFD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
